mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side bus bundle for mem_arbiter
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter in front of a single-port RAM
// Data wins ties until STARVE_MAX back-to-back data grants have starved a waiting fetch.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic          err
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    localparam logic [31:0] ERR_WORD = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state_q;
    logic [CW-1:0] starve_q;
    logic          err_q;

    logic d_req, ram_access, ram_err, ram_done;
    logic i_own, d_own, i_act, d_act, i_done, d_done;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.iaddr[1:0], bus.daddr[1:0]};

    assign d_req      = bus.dREN | bus.dWEN;
    assign ram_access = (bus.ramstate == 2'd2);
    assign ram_err    = (bus.ramstate == 2'd3);
    assign ram_done   = ram_access | ram_err;

    // Gating with RST keeps strobes low and suppresses completion in the reset cycle itself.
    assign i_own  = (state_q == IGRANT) & ~RST;
    assign d_own  = (state_q == DGRANT) & ~RST;
    assign i_act  = i_own & bus.iREN;
    assign d_act  = d_own & d_req;
    assign i_done = i_act & ram_done;
    assign d_done = d_act & ram_done;

    assign bus.iwait    = ~i_done;
    assign bus.dwait    = ~d_done;
    assign bus.ramREN   = i_act | (d_own & bus.dREN & ~bus.dWEN);
    assign bus.ramWEN   = d_own & bus.dWEN;
    assign bus.ramaddr  = i_own ? {bus.iaddr[31:2], 2'b00} :
                          d_own ? {bus.daddr[31:2], 2'b00} : 32'h0;
    assign bus.ramstore = d_own ? bus.dstore : 32'h0;
    assign bus.iload    = (i_own & ram_err) ? ERR_WORD : bus.ramload;
    assign bus.dload    = (d_own & ram_err) ? ERR_WORD : bus.ramload;
    assign err          = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_req && !(bus.iREN && starve_q == SMAX))
                        state_q <= DGRANT;
                    else if (bus.iREN)
                        state_q <= IGRANT;
                end
                IGRANT: if (!bus.iREN || ram_done) state_q <= IDLE;
                DGRANT: if (!d_req || ram_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (d_done) begin
                if (!bus.iREN)
                    starve_q <= '0;
                else if (starve_q != SMAX)
                    starve_q <= starve_q + 1'b1;
            end else if (i_done) begin
                starve_q <= '0;
            end

            if ((i_done | d_done) && ram_err)
                err_q <= 1'b1;
        end
    end
endmodule
